ringosc_cnt_reader: RTL and testbench

- Measurement controller on the far end of the ring-oscillator counter's pin interface.
- Drives the counter's reset, stop and shift[5:0] inputs and reads its 8-bit cnt output back.
- Per measurement it clears the counter, opens a fixed gate window, freezes the count, then reads the frozen count a byte at a time via shift and assembles a wide result.
- Sits in the user-logic clock domain and feeds result/done to a host or readout block.

---
 rtl/ringosc_cnt_reader.sv | 140 ++++++++++++++
 tb/tb_ringosc_cnt_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ringosc_cnt_reader.sv
// rtl/ringosc_cnt_reader.sv - gated ring-oscillator count measurement with byte-wise readout
module ringosc_cnt_reader #(
   parameter int GATE_CYCLES   = 1000,
   parameter int CLEAR_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int NBYTES        = 3,
   parameter int RES_W         = 8 * NBYTES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [7:0]       cnt_i,
   output logic             osc_reset_o,
   output logic             osc_stop_o,
   output logic [5:0]       osc_shift_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [RES_W-1:0] result_o
);
   localparam int CYC_W = $clog2(GATE_CYCLES + CLEAR_CYCLES + SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_READ, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [2:0]       k_q, k_d;
   logic [7:0]       cnt_m, cnt_s;
   logic [RES_W-1:0] shadow_q, shadow_d, result_d;
   logic             reset_d, stop_d, busy_d, done_d;
   logic [5:0]       shift_d;

   // cnt_i comes from the oscillator domain; only cnt_s is ever used
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_m <= '0;
         cnt_s <= '0;
      end else begin
         cnt_m <= cnt_i;
         cnt_s <= cnt_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cyc_q       <= '0;
         k_q         <= '0;
         shadow_q    <= '0;
         result_o    <= '0;
         osc_reset_o <= 1'b1;
         osc_stop_o  <= 1'b1;
         osc_shift_o <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         k_q         <= k_d;
         shadow_q    <= shadow_d;
         result_o    <= result_d;
         osc_reset_o <= reset_d;
         osc_stop_o  <= stop_d;
         osc_shift_o <= shift_d;
         busy_o      <= busy_d;
         done_o      <= done_d;
      end
   end

   // Outputs are computed for the state being entered, so they line up with state_q
   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      k_d      = k_q;
      shadow_d = shadow_q;
      result_d = result_o;
      reset_d  = osc_reset_o;
      stop_d   = osc_stop_o;
      shift_d  = osc_shift_o;
      busy_d   = busy_o;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start_i) begin
               state_d = S_CLEAR;
               cyc_d   = '0;
               reset_d = 1'b1;
               stop_d  = 1'b1;
               shift_d = '0;
               busy_d  = 1'b1;
            end
         end
         S_CLEAR: begin
            if (cyc_q == CYC_W'(CLEAR_CYCLES - 1)) begin
               state_d = S_RUN;
               cyc_d   = '0;
               reset_d = 1'b0;
               stop_d  = 1'b0;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         S_RUN: begin
            if (cyc_q == CYC_W'(GATE_CYCLES - 1)) begin
               state_d = S_READ;
               cyc_d   = '0;
               k_d     = '0;
               stop_d  = 1'b1;
               shift_d = '0;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         S_READ: begin
            if (cyc_q == CYC_W'(SETTLE_CYCLES - 1)) begin
               cyc_d = '0;
               for (int b = 0; b < NBYTES; b++) begin
                  if (k_q == 3'(b)) shadow_d[8*b +: 8] = cnt_s;
               end
               if (k_q == 3'(NBYTES - 1)) begin
                  state_d  = S_DONE;
                  result_d = shadow_d;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
               end else begin
                  k_d     = k_q + 3'd1;
                  shift_d = {k_d, 3'b000};
               end
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_ringosc_cnt_reader.sv
// tb/tb_ringosc_cnt_reader.sv - self-checking bench for ringosc_cnt_reader
module tb_ringosc_cnt_reader;
   localparam int CLEAR_C  = 2;
   localparam int NB       = 3;
   localparam int GATE_A   = 1000;
   localparam int SETTLE_A = 4;
   localparam int GATE_B   = 300;
   localparam int SETTLE_B = 5;
   localparam int LAT_A    = CLEAR_C + GATE_A + NB * SETTLE_A;
   localparam int LAT_B    = CLEAR_C + GATE_B + NB * SETTLE_B;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, start_a, rst_b, start_b;
   logic [7:0]  cnt_a, cnt_b;
   logic        osc_reset_a, osc_stop_a, osc_reset_b, osc_stop_b;
   logic [5:0]  osc_shift_a, osc_shift_b;
   logic        busy_a, done_a, busy_b, done_b;
   logic [23:0] result_a, result_b;

   int n_tests = 0;
   int n_fail  = 0;

   ringosc_cnt_reader #(.GATE_CYCLES(GATE_A), .CLEAR_CYCLES(CLEAR_C), .SETTLE_CYCLES(SETTLE_A),
                        .NBYTES(NB)) dut_a (
      .clk(clk), .rst(rst_a), .start_i(start_a), .cnt_i(cnt_a),
      .osc_reset_o(osc_reset_a), .osc_stop_o(osc_stop_a), .osc_shift_o(osc_shift_a),
      .busy_o(busy_a), .done_o(done_a), .result_o(result_a));

   ringosc_cnt_reader #(.GATE_CYCLES(GATE_B), .CLEAR_CYCLES(CLEAR_C), .SETTLE_CYCLES(SETTLE_B),
                        .NBYTES(NB)) dut_b (
      .clk(clk), .rst(rst_b), .start_i(start_b), .cnt_i(cnt_b),
      .osc_reset_o(osc_reset_b), .osc_stop_o(osc_stop_b), .osc_shift_o(osc_shift_b),
      .busy_o(busy_b), .done_o(done_b), .result_o(result_b));

   // Counter models: A counts once per 3 clk, B adds step_b per clk; both garble cnt after shift moves
   logic [31:0] ctr_a = '0, ctr_b = '0, step_b = '0;
   int          div_a = 0;
   logic [5:0]  sh1_a = '0, sh1_b = '0, sh2_b = '0;
   logic [31:0] byte_a, byte_b;

   always @(posedge clk) begin
      sh1_a <= osc_shift_a;
      sh1_b <= osc_shift_b;
      sh2_b <= sh1_b;
      if (osc_reset_a === 1'b1) begin
         ctr_a <= '0;
         div_a <= 0;
      end else if (osc_stop_a === 1'b0) begin
         if (div_a == 2) begin
            div_a <= 0;
            ctr_a <= ctr_a + 32'd1;
         end else begin
            div_a <= div_a + 1;
         end
      end
      if (osc_reset_b === 1'b1) ctr_b <= '0;
      else if (osc_stop_b === 1'b0) ctr_b <= ctr_b + step_b;
   end

   assign byte_a = ctr_a >> osc_shift_a;
   assign byte_b = ctr_b >> osc_shift_b;
   assign cnt_a  = (osc_shift_a != sh1_a) ? ~byte_a[7:0] : byte_a[7:0];
   assign cnt_b  = (osc_shift_b != sh1_b || sh1_b != sh2_b) ? ~byte_b[7:0] : byte_b[7:0];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic measure_b(input logic [31:0] step, output logic [23:0] res, output int lat);
      step_b = step;
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      lat = 0;
      while (done_b !== 1'b1 && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      res = result_b;
   endtask

   typedef struct {
      logic [31:0] step;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int          lat, t1, unstable, dones, last_sh;
      int          shq[$];
      int          exp_sh[3];
      logic [23:0] res, ex;
      logic [31:0] s;

      vecs[0] = '{32'd1,     24'd300};
      vecs[1] = '{32'd233,   24'd69900};
      vecs[2] = '{32'd55924, 24'd16777200};
      vecs[3] = '{32'd55925, 24'd284};
      vecs[4] = '{32'd0,     24'd0};
      exp_sh  = '{0, 8, 16};

      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_osc_reset", osc_reset_a, 1);
      check("rst_osc_stop", osc_stop_a, 1);
      check("rst_shift", osc_shift_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_result", result_a, 0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      // Single measurement, with a start pulse during busy that must be ignored
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      check("busy_after_start", busy_a, 1);
      check("reset_in_clear", osc_reset_a, 1);
      lat = 0;
      last_sh = int'(osc_shift_a);
      shq.push_back(last_sh);
      while (done_a !== 1'b1 && lat < 3000) begin
         @(negedge clk);
         lat++;
         if (int'(osc_shift_a) != last_sh) begin
            last_sh = int'(osc_shift_a);
            shq.push_back(last_sh);
         end
         if (lat == 100) start_a = 1'b1;
         if (lat == 101) start_a = 1'b0;
         if (lat == 500) begin
            check("stop_in_run", osc_stop_a, 0);
            check("reset_in_run", osc_reset_a, 0);
         end
      end
      check("latency_a", lat, LAT_A);
      check("result_a", result_a, 333);
      check("busy_in_done", busy_a, 0);
      check("shift_steps", shq.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < shq.size()) check($sformatf("shift_seq%0d", i), shq[i], exp_sh[i]);
      end
      @(negedge clk);
      check("done_one_cycle", done_a, 0);
      repeat (3) @(negedge clk);
      check("no_queued_start", busy_a, 0);
      check("idle_frozen_stop", osc_stop_a, 1);
      check("idle_frozen_reset", osc_reset_a, 0);
      check("idle_result_hold", result_a, 333);

      // Reset in the middle of the gate window
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      repeat (500) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      check("midrst_osc_reset", osc_reset_a, 1);
      check("midrst_osc_stop", osc_stop_a, 1);
      check("midrst_busy", busy_a, 0);
      check("midrst_result", result_a, 0);
      check("midrst_done", done_a, 0);
      rst_a = 1'b0;
      dones = 0;
      repeat (1200) begin
         @(negedge clk);
         if (done_a === 1'b1) dones++;
      end
      check("no_done_after_rst", dones, 0);

      // start_i held high: back-to-back measurements
      start_a = 1'b1;
      lat = 0;
      while (done_a !== 1'b1 && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_first_result", result_a, 333);
      res = result_a;
      unstable = 0;
      t1 = 0;
      do begin
         @(negedge clk);
         t1++;
         if (done_a !== 1'b1 && result_a !== res) unstable++;
      end while (done_a !== 1'b1 && t1 < 3000);
      check("b2b_gap", t1, LAT_A + 2);
      check("b2b_result_stable", unstable, 0);
      check("b2b_second_result", result_a, 333);
      start_a = 1'b0;

      // Table vectors on the fast-counting instance, incl. byte 2 and wrap-around
      for (int i = 0; i < 5; i++) begin
         measure_b(vecs[i].step, res, lat);
         check($sformatf("vec%0d_latency", i), lat, LAT_B);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      end

      // Random step sizes against count = gate * step mod 2^24
      for (int i = 0; i < 6; i++) begin
         s  = $urandom;
         ex = 24'(64'(GATE_B) * 64'(s));
         measure_b(s, res, lat);
         check($sformatf("rand%0d_result", i), res, ex);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
